// File: rtl/spram_banked_ctl.sv
// spram_banked_ctl: byte-addressed req/ready controller over BANKS x 16b x 16K SPRAM banks, halfwords interleaved.
// Optional bank standby sequencing is compiled in with `define SPRAM_PWRSAVE_EN.
module spram_banked_ctl #(
    parameter  int BANKS   = 4,
    parameter  int RSP_REG = 0,
    localparam int AW      = 15 + $clog2(BANKS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [1:0]    req_size_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic [31:0]   req_wdata_i,
    output logic          rsp_valid_o,
    output logic [31:0]   rsp_rdata_o,
    output logic          rsp_err_o
);
    localparam int LB   = $clog2(BANKS);
    localparam int BW   = (BANKS > 1) ? LB : 1;
    localparam int HW   = AW - 1;
    localparam int ROWS = 16384;

`ifdef SPRAM_PWRSAVE_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HI = 2'd1, ST_WAKE = 2'd2} state_e;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HI = 2'd1} state_e;
`endif

    state_e        state_q, state_d;
    logic [BW-1:0] hi_bank_q, hi_bank_d, rd_bank_q, rd_bank_d;
    logic [13:0]   hi_row_q, hi_row_d;
    logic          hi_we_q, hi_we_d;
    logic [15:0]   hi_wdata_q, hi_wdata_d, lo_q, lo_d;
    logic          s1_valid_q, s1_valid_d, s1_err_q, s1_err_d;
    logic          s1_word_q, s1_word_d, s1_byte_q, s1_byte_d, s1_bsel_q, s1_bsel_d;
    logic [31:0]   hold_q, hold_d, rsp_cur_s, fmt_s;
    logic [15:0]   rd_do_s;

    logic [HW-1:0] req_h_s, hi_h_s;
    logic [BW-1:0] req_bank_s, hi_bank_s;
    logic [13:0]   req_row_s, hi_row_s;
    logic          is_byte_s, is_word_s, illegal_s, wake_s, req_ready_s;

    logic          ram_en_s, ram_we_s;
    logic [BW-1:0] ram_bank_s;
    logic [13:0]   ram_row_s;
    logic [15:0]   ram_din_s;
    logic [3:0]    ram_mask_s;
    logic [BANKS-1:0]       stdby_s;
    logic [BANKS-1:0][15:0] do_all_s;
    logic          sleep_s, pwroff_n_s;

    assign sleep_s    = 1'b0;
    assign pwroff_n_s = 1'b1;

    assign req_h_s   = req_addr_i[AW-1:1];
    assign hi_h_s    = req_h_s + HW'(1'b1);
    assign req_row_s = 14'(req_h_s >> LB);
    assign hi_row_s  = 14'(hi_h_s >> LB);
    assign is_byte_s = (req_size_i == 2'd0);
    assign is_word_s = (req_size_i == 2'd2);
    assign illegal_s = (req_size_i == 2'd3) || ((req_size_i == 2'd1) && req_addr_i[0]) ||
                       (is_word_s && (req_addr_i[1:0] != 2'b00));

    if (BANKS > 1) begin : g_multi
        assign req_bank_s = req_h_s[BW-1:0];
        assign hi_bank_s  = hi_h_s[BW-1:0];
    end else begin : g_single
        assign req_bank_s = 1'b0;
        assign hi_bank_s  = 1'b0;
    end

`ifdef SPRAM_PWRSAVE_EN
    logic [BANKS-1:0] stdby_q, stdby_d, need_mask_s;
    assign need_mask_s = (BANKS'(1'b1) << req_bank_s) |
                         (is_word_s ? (BANKS'(1'b1) << hi_bank_s) : {BANKS{1'b0}});
    assign wake_s  = req_valid_i && !illegal_s && ((need_mask_s & stdby_q) != {BANKS{1'b0}});
    assign stdby_s = stdby_q;

    // Standby tracking: wake only the targets, then keep awake just what the accepted access touched.
    always_comb begin
        stdby_d = stdby_q;
        if ((state_q != ST_HI) && req_valid_i && !illegal_s) begin
            stdby_d = wake_s ? (stdby_q & ~need_mask_s) : ~need_mask_s;
        end else begin
            stdby_d = stdby_q;
        end
    end

    // Standby register; only bank 0 is awake out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stdby_q <= ~(BANKS'(1'b1));
        else        stdby_q <= stdby_d;
    end
`else
    assign wake_s  = 1'b0;
    assign stdby_s = {BANKS{1'b0}};
`endif

    // Request FSM and SRAM command; WAKE shares the IDLE accept path once its banks are up.
    always_comb begin
        state_d    = state_q;
        hi_bank_d  = hi_bank_q;
        hi_row_d   = hi_row_q;
        hi_we_d    = hi_we_q;
        hi_wdata_d = hi_wdata_q;
        lo_d       = lo_q;
        s1_valid_d = 1'b0;
        s1_err_d   = 1'b0;
        s1_word_d  = 1'b0;
        s1_byte_d  = 1'b0;
        s1_bsel_d  = 1'b0;
        ram_en_s   = 1'b0;
        ram_we_s   = 1'b0;
        ram_bank_s = req_bank_s;
        ram_row_s  = req_row_s;
        ram_din_s  = req_wdata_i[15:0];
        ram_mask_s = 4'b1111;
        req_ready_s = 1'b0;
        case (state_q)
            ST_HI: begin
                ram_en_s   = 1'b1;
                ram_we_s   = hi_we_q;
                ram_bank_s = hi_bank_q;
                ram_row_s  = hi_row_q;
                ram_din_s  = hi_wdata_q;
                lo_d       = do_all_s[rd_bank_q];
                s1_valid_d = !hi_we_q;
                s1_word_d  = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                req_ready_s = !wake_s;
                if (req_valid_i && !wake_s) begin
                    state_d = ST_IDLE;
                    if (illegal_s) begin
                        s1_valid_d = !req_we_i;
                        s1_err_d   = 1'b1;
                    end else begin
                        ram_en_s  = 1'b1;
                        ram_we_s  = req_we_i;
                        s1_byte_d = is_byte_s;
                        s1_bsel_d = req_addr_i[0];
                        if (is_byte_s) begin
                            ram_din_s  = {2{req_wdata_i[7:0]}};
                            ram_mask_s = req_addr_i[0] ? 4'b1100 : 4'b0011;
                        end else begin
                            ram_mask_s = 4'b1111;
                        end
                        if (is_word_s) begin
                            state_d    = ST_HI;
                            hi_bank_d  = hi_bank_s;
                            hi_row_d   = hi_row_s;
                            hi_we_d    = req_we_i;
                            hi_wdata_d = req_wdata_i[31:16];
                        end else begin
                            s1_valid_d = !req_we_i;
                        end
                    end
                end else begin
`ifdef SPRAM_PWRSAVE_EN
                    state_d = wake_s ? ST_WAKE : ST_IDLE;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
        endcase
        if (ram_en_s && !ram_we_s) rd_bank_d = ram_bank_s;
        else                       rd_bank_d = rd_bank_q;
    end

    assign req_ready_o = req_ready_s;

    // Read data formatting from the registered bank select; output holds between responses.
    always_comb begin
        rd_do_s = do_all_s[rd_bank_q];
        if (s1_err_q)       fmt_s = 32'h0000_0000;
        else if (s1_word_q) fmt_s = {rd_do_s, lo_q};
        else if (s1_byte_q) fmt_s = {24'h00_0000, s1_bsel_q ? rd_do_s[15:8] : rd_do_s[7:0]};
        else                fmt_s = {16'h0000, rd_do_s};
        rsp_cur_s = s1_valid_q ? fmt_s : hold_q;
        hold_d    = rsp_cur_s;
    end

    // Control and response-stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            hi_bank_q  <= {BW{1'b0}};
            hi_row_q   <= 14'h0000;
            hi_we_q    <= 1'b0;
            hi_wdata_q <= 16'h0000;
            rd_bank_q  <= {BW{1'b0}};
            lo_q       <= 16'h0000;
            s1_valid_q <= 1'b0;
            s1_err_q   <= 1'b0;
            s1_word_q  <= 1'b0;
            s1_byte_q  <= 1'b0;
            s1_bsel_q  <= 1'b0;
            hold_q     <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            hi_bank_q  <= hi_bank_d;
            hi_row_q   <= hi_row_d;
            hi_we_q    <= hi_we_d;
            hi_wdata_q <= hi_wdata_d;
            rd_bank_q  <= rd_bank_d;
            lo_q       <= lo_d;
            s1_valid_q <= s1_valid_d;
            s1_err_q   <= s1_err_d;
            s1_word_q  <= s1_word_d;
            s1_byte_q  <= s1_byte_d;
            s1_bsel_q  <= s1_bsel_d;
            hold_q     <= hold_d;
        end
    end

    if (RSP_REG != 0) begin : g_rsp_reg
        logic        out_valid_q, out_err_q;
        logic [31:0] out_rdata_q;
        // Optional extra response register stage.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_valid_q <= 1'b0;
                out_err_q   <= 1'b0;
                out_rdata_q <= 32'h0000_0000;
            end else begin
                out_valid_q <= s1_valid_q;
                out_err_q   <= s1_err_q;
                out_rdata_q <= rsp_cur_s;
            end
        end
        assign rsp_valid_o = out_valid_q;
        assign rsp_err_o   = out_err_q;
        assign rsp_rdata_o = out_rdata_q;
    end else begin : g_rsp_direct
        assign rsp_valid_o = s1_valid_q;
        assign rsp_err_o   = s1_err_q;
        assign rsp_rdata_o = rsp_cur_s;
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic [15:0] mem_q [ROWS];
        logic [15:0] do_q, bitmask_s;
        logic        sel_s;
        assign sel_s = ram_en_s && (ram_bank_s == BW'(b)) && !stdby_s[b] && !sleep_s && pwroff_n_s;
        assign bitmask_s = {{4{ram_mask_s[3]}}, {4{ram_mask_s[2]}}, {4{ram_mask_s[1]}}, {4{ram_mask_s[0]}}};
        // SP256K array: nibble-masked synchronous write, registered read data.
        always_ff @(posedge clk) begin
            if (sel_s && ram_we_s) mem_q[ram_row_s] <= (mem_q[ram_row_s] & ~bitmask_s) | (ram_din_s & bitmask_s);
            else if (sel_s)        do_q <= mem_q[ram_row_s];
            else                   do_q <= do_q;
        end
        assign do_all_s[b] = do_q;
    end
endmodule

// File: tb/tb_spram_banked_ctl.sv
// Directed self-checking bench for spram_banked_ctl (default 4 banks, RSP_REG selectable below).
module tb_spram_banked_ctl;
    localparam int BANKS   = 4;
    localparam int RSP_REG = 0;
    localparam int AW      = 15 + $clog2(BANKS);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0, req_we = 1'b0;
    logic [1:0]    req_size = 2'd0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = 32'h0;
    logic          req_ready, rsp_valid, rsp_err;
    logic [31:0]   rsp_rdata;
    int            n_cmp = 0, n_bad = 0;

    localparam logic [AW-1:0] B2B_ADDR [4] = '{17'h00, 17'h02, 17'h04, 17'h06};
    localparam logic [31:0]   B2B_EXP  [4] = '{32'h1111, 32'h2222, 32'h3333, 32'h4444};
    localparam logic [1:0]    BH_SIZE  [3] = '{2'd1, 2'd0, 2'd0};
    localparam logic [AW-1:0] BH_ADDR  [3] = '{17'h20, 17'h21, 17'h20};
    localparam logic [31:0]   BH_EXP   [3] = '{32'h0000_1122, 32'h0000_0011, 32'h0000_0022};

    always #5 clk = ~clk;

    spram_banked_ctl #(.BANKS(BANKS), .RSP_REG(RSP_REG)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_size_i(req_size), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
    );

    task automatic set_req(input logic v, input logic we, input logic [1:0] sz,
                           input logic [AW-1:0] a, input logic [31:0] d);
        req_valid = v; req_we = we; req_size = sz; req_addr = a; req_wdata = d;
    endtask

    task automatic wait_rsp();
        if (RSP_REG != 0) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_req(1'b0, 1'b0, 2'd0, '0, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", rsp_err); end
        n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", rsp_rdata); end
        @(negedge clk);
        set_req(1'b1, 1'b1, 2'd2, 17'h40, 32'hCAFE_F00D);
        @(negedge clk);
        set_req(1'b0, 1'b0, 2'd0, '0, 32'h0);
        #1;
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL midword_busy: got %b want 0", req_ready); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid[%0d]: got %b want 0", i, rsp_valid); end
            n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL midrst_err[%0d]: got %b want 0", i, rsp_err); end
            n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready[%0d]: got %b want 1", i, req_ready); end
            @(negedge clk);
        end
    endtask

    task automatic test_word();
        set_req(1'b1, 1'b1, 2'd2, 17'h10, 32'hDEAD_BEEF);
        @(negedge clk);
        set_req(1'b0, 1'b0, 2'd0, '0, 32'h0);
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL wwr_hi_busy: got %b want 0", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL wwr_no_rsp: got %b want 0", rsp_valid); end
        @(negedge clk);
        set_req(1'b1, 1'b0, 2'd2, 17'h10, 32'h0);
        @(negedge clk);
        set_req(1'b0, 1'b0, 2'd0, '0, 32'h0);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL wrd_early: got %b want 0", rsp_valid); end
        @(negedge clk);
        wait_rsp();
        n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL wrd_valid: got %b want 1", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wrd_data: got %h want deadbeef", rsp_rdata); end
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL wrd_pulse: got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wrd_hold: got %h want deadbeef", rsp_rdata); end
    endtask

    task automatic test_byte_half();
        set_req(1'b1, 1'b1, 2'd0, 17'h21, 32'hAB00_CD11);
        @(negedge clk);
        set_req(1'b1, 1'b1, 2'd0, 17'h20, 32'hFFFF_EE22);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            set_req(1'b1, 1'b0, BH_SIZE[i], BH_ADDR[i], 32'h0);
            @(negedge clk);
            set_req(1'b0, 1'b0, 2'd0, '0, 32'h0);
            wait_rsp();
            n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL bh_valid[%0d]: got %b want 1", i, rsp_valid); end
            n_cmp++; if (rsp_rdata !== BH_EXP[i]) begin n_bad++; $display("FAIL bh_data[%0d]: got %h want %h", i, rsp_rdata, BH_EXP[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        set_req(1'b1, 1'b0, 2'd1, 17'h03, 32'h0);
        @(negedge clk);
        set_req(1'b0, 1'b0, 2'd0, '0, 32'h0);
        wait_rsp();
        n_cmp++; if (rsp_err !== 1'b1) begin n_bad++; $display("FAIL mis_half_err: got %b want 1", rsp_err); end
        n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL mis_half_valid: got %b want 1", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL mis_half_data: got %h want 0", rsp_rdata); end
        @(negedge clk);
        n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL mis_half_pulse: got %b want 0", rsp_err); end
        set_req(1'b1, 1'b1, 2'd3, 17'h10, 32'hFFFF_FFFF);
        @(negedge clk);
        set_req(1'b0, 1'b0, 2'd0, '0, 32'h0);
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL sz3_ready: got %b want 1", req_ready); end
        wait_rsp();
        n_cmp++; if (rsp_err !== 1'b1) begin n_bad++; $display("FAIL sz3_err: got %b want 1", rsp_err); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL sz3_valid: got %b want 0", rsp_valid); end
        @(negedge clk);
        set_req(1'b1, 1'b0, 2'd2, 17'h12, 32'h0);
        @(negedge clk);
        set_req(1'b0, 1'b0, 2'd0, '0, 32'h0);
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL mis_word_ready: got %b want 1", req_ready); end
        wait_rsp();
        n_cmp++; if (rsp_err !== 1'b1) begin n_bad++; $display("FAIL mis_word_err: got %b want 1", rsp_err); end
        @(negedge clk);
        set_req(1'b1, 1'b0, 2'd2, 17'h10, 32'h0);
        @(negedge clk);
        set_req(1'b0, 1'b0, 2'd0, '0, 32'h0);
        @(negedge clk);
        wait_rsp();
        n_cmp++; if (rsp_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL sz3_ram_kept: got %h want deadbeef", rsp_rdata); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int k;
        set_req(1'b1, 1'b1, 2'd2, 17'h00, 32'h2222_1111);
        @(negedge clk);
        set_req(1'b0, 1'b0, 2'd0, '0, 32'h0);
        @(negedge clk);
        set_req(1'b1, 1'b1, 2'd2, 17'h04, 32'h4444_3333);
        @(negedge clk);
        set_req(1'b0, 1'b0, 2'd0, '0, 32'h0);
        @(negedge clk);
        set_req(1'b1, 1'b1, 2'd1, 17'h08, 32'h0000_5A5A);
        @(negedge clk);
        set_req(1'b1, 1'b0, 2'd1, 17'h08, 32'h0);
        @(negedge clk);
        set_req(1'b0, 1'b0, 2'd0, '0, 32'h0);
        wait_rsp();
        n_cmp++; if (rsp_rdata !== 32'h0000_5A5A) begin n_bad++; $display("FAIL wr_then_rd: got %h want 00005a5a", rsp_rdata); end
        @(negedge clk);
        for (int i = 0; i < 6 + RSP_REG; i++) begin
            k = i - 1 - RSP_REG;
            if (k >= 0 && k < 4) begin
                n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, rsp_valid); end
                n_cmp++; if (rsp_rdata !== B2B_EXP[k]) begin n_bad++; $display("FAIL b2b_data[%0d]: got %h want %h", i, rsp_rdata, B2B_EXP[k]); end
            end else begin
                n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_idle[%0d]: got %b want 0", i, rsp_valid); end
            end
            if (i < 4) begin
                n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, req_ready); end
                set_req(1'b1, 1'b0, 2'd1, B2B_ADDR[i], 32'h0);
            end else begin
                set_req(1'b0, 1'b0, 2'd0, '0, 32'h0);
            end
            @(negedge clk);
        end
    endtask

`ifdef SPRAM_PWRSAVE_EN
    task automatic test_pwrsave();
        int n;
        n = 0;
        set_req(1'b1, 1'b0, 2'd1, 17'h00, 32'h0);
        #1;
        while (!req_ready && n < 4) begin @(negedge clk); #1; n++; end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL ps_bank0_timeout: got %b want 1", req_ready); end
        @(negedge clk);
        set_req(1'b0, 1'b0, 2'd0, '0, 32'h0);
        repeat (3) @(negedge clk);
        set_req(1'b1, 1'b0, 2'd1, 17'h04, 32'h0);
        #1;
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL ps_wake_stall: got %b want 0", req_ready); end
        @(negedge clk);
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL ps_wake_ready: got %b want 1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL ps_early: got %b want 0", rsp_valid); end
        @(negedge clk);
        set_req(1'b0, 1'b0, 2'd0, '0, 32'h0);
        wait_rsp();
        n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL ps_valid: got %b want 1", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 32'h0000_3333) begin n_bad++; $display("FAIL ps_data: got %h want 00003333", rsp_rdata); end
        @(negedge clk);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_word();
        test_byte_half();
        test_illegal();
        test_back_to_back();
`ifdef SPRAM_PWRSAVE_EN
        test_pwrsave();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
